video_layer_ports: RTL and testbench
====================================

// Module: video_layer_ports
// PURPOSE
//  Parametrised, address-decoded register bank holding per-layer scroll/page parameters for
//  LAYERS video layers. X offset and graphics page are double-buffered (shadow -> active at
//  line start, or at frame start per layer mode). Y offset can auto-scroll by a per-layer
//  increment every frame, wrapping at YWRAP. Sits between the Z80 port decoder and the renderers.
// PARAMETERS
//  LAYERS     4      number of layers (1..8)
//  OFFS_W     9      offset width in bits (9..16)
//  YWRAP      320    Y auto-scroll modulus (2..2**OFFS_W)
//  GPAGE_RST  8'h00  reset value of shadow and active gpage
// PORTS
//  clk           in   1               system clock
//  res           in   1               synchronous active-high reset
//  addr          in   AW=clog2(LAYERS)+3  register address: {layer, reg[2:0]}
//  d             in   8               write data
//  wr            in   1               write strobe, one cycle per write
//  line_start_s  in   1               line-start pulse
//  int_start     in   1               frame-start pulse
//  x_offs        out  LAYERS*OFFS_W   active X offsets, layer n at [n*OFFS_W +: OFFS_W]
//  y_offs        out  LAYERS*OFFS_W   active Y offsets, same packing
//  gpage         out  LAYERS*8        active graphics pages
//  rd_data       out  8               readback, registered
// BEHAVIOUR
//  Reg map per layer: 0 xl, 1 xh, 2 yl, 3 yh, 4 gpage, 5 ctrl, 6-7 reserved (writes ignored, read 0).
//  xh/yh: d[OFFS_W-9:0] -> bits OFFS_W-1:8; upper d bits ignored, read back 0.
//  ctrl: bit0 sync (0 = line, 1 = frame); bits7:4 yinc (unsigned); bits3:1 stored, no effect.
//  Layers >= LAYERS (non-power-of-2): writes ignored, reads 0.
//  Reset: all shadow/active X, Y and ctrl = 0; gpage shadow/active = GPAGE_RST; rd_data = 0.
//  res overrides wr, line_start_s and int_start in the same cycle.
//  X/gpage: wr updates shadow next edge. Copy shadow->active:
//   - sync=0: on line_start_s or int_start;
//   - sync=1: on int_start only.
//   Same-cycle wr and copy: active takes OLD shadow, new value appears at the next copy event.
//  Y: wr updates active Y directly, visible the cycle after the write.
//   On int_start, per layer: s = y + yinc (OFFS_W+1 bits); y <= (s >= YWRAP) ? s - YWRAP : s.
//   Exactly one subtraction per frame; an out-of-range written Y may stay >= YWRAP, not clamped.
//   yinc = 0: Y holds.
//   Same-cycle Y write and int_start: write wins, no increment for that byte's register;
//   the other byte also holds that cycle.
//  Readback: rd_data valid one cycle after addr (no rd strobe), sampled every cycle.
//   Returns: X and gpage = shadow; Y = active; ctrl = full stored byte.
//  Latency: shadow = 1 clk; active X/gpage = 1 clk after the copy pulse;
//   Y auto-increment = 1 clk after int_start.
//  Layers are independent; no cross-layer state.
// TESTING
//  T1 reset: assert res 1 clk -> all x_offs/y_offs 0, gpage = GPAGE_RST, rd_data 0;
//     wr same cycle as res -> no effect.
//  T2 line sync: L1 xl=0x34, xh=0x01 -> x_offs[L1] stays 0 until line_start_s, then 0x134;
//     wr xl=0x55 on the same cycle as line_start_s -> active stays 0x134 until the next pulse.
//  T3 frame sync: L0 ctrl=0x01, gpage=0xA0; 3 line_start_s -> gpage[L0] unchanged;
//     int_start -> gpage[L0]=0xA0.
//  T4 auto-scroll: L2 y=318, ctrl=0x30 (yinc=3); int_start x3 -> y = 1, 4, 7 (YWRAP=320).
//     L2 yl write same cycle as int_start -> written value kept, no increment.
//  T5 readback/decode: write all regs in every layer, read each back one clk later; expect
//     reserved = 0, xh/yh upper bits 0; with LAYERS=3, writes to layer 3 -> no output changes.
//  T6 reset mid-frame: pending shadow X, yinc set, res pulse then int_start -> all active = reset values.

Source files
------------

// File: rtl/video_layer_ports.sv
// Per-layer scroll/page register bank between the Z80 port decoder and the
// video renderers. X offset and graphics page are double-buffered (shadow ->
// active on a line or frame event). Y offset is written directly and can
// auto-scroll once per frame by a per-layer increment, wrapping at YWRAP.
module video_layer_ports #(
  parameter int          LAYERS    = 4,
  parameter int          OFFS_W    = 9,
  parameter int          YWRAP     = 320,
  parameter logic [7:0]  GPAGE_RST = 8'h00,
  localparam int         AW        = $clog2(LAYERS) + 3
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [AW-1:0]            addr,
  input  logic [7:0]               d,
  input  logic                     wr,
  input  logic                     line_start_s,
  input  logic                     int_start,
  output logic [LAYERS*OFFS_W-1:0] x_offs,
  output logic [LAYERS*OFFS_W-1:0] y_offs,
  output logic [LAYERS*8-1:0]      gpage,
  output logic [7:0]               rd_data
);

  typedef enum logic [2:0] {
    REG_XL    = 3'd0,
    REG_XH    = 3'd1,
    REG_YL    = 3'd2,
    REG_YH    = 3'd3,
    REG_GPAGE = 3'd4,
    REG_CTRL  = 3'd5,
    REG_RSV6  = 3'd6,
    REG_RSV7  = 3'd7
  } reg_e;

  typedef logic [OFFS_W-1:0] offs_t;

  localparam logic [OFFS_W:0] YWRAP_W = (OFFS_W+1)'(YWRAP);

  offs_t      x_sh_q  [LAYERS];
  offs_t      x_sh_d  [LAYERS];
  offs_t      x_act_q [LAYERS];
  offs_t      x_act_d [LAYERS];
  offs_t      y_q     [LAYERS];
  offs_t      y_d     [LAYERS];
  logic [7:0] gp_sh_q  [LAYERS];
  logic [7:0] gp_sh_d  [LAYERS];
  logic [7:0] gp_act_q [LAYERS];
  logic [7:0] gp_act_d [LAYERS];
  logic [7:0] ctrl_q   [LAYERS];
  logic [7:0] ctrl_d   [LAYERS];
  logic [7:0] rd_q;
  logic [7:0] rd_d;

  // Address split: layer index in the upper bits, register select in [2:0].
  // Shifting (rather than slicing) keeps this legal when LAYERS == 1.
  logic [AW-1:0] sel_layer;
  reg_e          reg_sel;
  assign sel_layer = addr >> 3;
  assign reg_sel   = reg_e'(addr[2:0]);

  logic [OFFS_W:0] y_sum;
  logic            copy_ev;
  logic            hit;

  // Next-state for every layer: copy events, Y auto-scroll, then CPU writes.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves a value unassigned and no latch is inferred.
    x_sh_d   = x_sh_q;
    x_act_d  = x_act_q;
    y_d      = y_q;
    gp_sh_d  = gp_sh_q;
    gp_act_d = gp_act_q;
    ctrl_d   = ctrl_q;
    y_sum    = '0;
    copy_ev  = 1'b0;
    hit      = 1'b0;
    for (int n = 0; n < LAYERS; n++) begin
      hit     = wr && (sel_layer == AW'(n));
      copy_ev = int_start || (line_start_s && !ctrl_q[n][0]);

      // Active copies read the registered shadow, so a same-cycle write is
      // only picked up at the following copy event.
      if (copy_ev) begin
        x_act_d[n]  = x_sh_q[n];
        gp_act_d[n] = gp_sh_q[n];
      end

      // One conditional subtraction per frame; a Y written out of range is
      // deliberately not clamped. A Y write in the same cycle suppresses the
      // increment for both bytes.
      y_sum = {1'b0, y_q[n]} + (OFFS_W+1)'(ctrl_q[n][7:4]);
      if (int_start && !(hit && (reg_sel == REG_YL || reg_sel == REG_YH))) begin
        if (y_sum >= YWRAP_W) y_d[n] = OFFS_W'(y_sum - YWRAP_W);
        else                  y_d[n] = OFFS_W'(y_sum);
      end

      if (hit) begin
        case (reg_sel)
          REG_XL:    x_sh_d[n][7:0]        = d;
          REG_XH:    x_sh_d[n][OFFS_W-1:8] = d[OFFS_W-9:0];
          REG_YL:    y_d[n][7:0]           = d;
          REG_YH:    y_d[n][OFFS_W-1:8]    = d[OFFS_W-9:0];
          REG_GPAGE: gp_sh_d[n]            = d;
          REG_CTRL:  ctrl_d[n]             = d;
          default:   ;
        endcase
      end
    end
  end

  // Readback mux: X/gpage report the shadow, Y the active value.
  always_comb begin
    rd_d = '0;
    for (int n = 0; n < LAYERS; n++) begin
      if (sel_layer == AW'(n)) begin
        case (reg_sel)
          REG_XL:    rd_d                = x_sh_q[n][7:0];
          REG_XH:    rd_d[OFFS_W-9:0]    = x_sh_q[n][OFFS_W-1:8];
          REG_YL:    rd_d                = y_q[n][7:0];
          REG_YH:    rd_d[OFFS_W-9:0]    = y_q[n][OFFS_W-1:8];
          REG_GPAGE: rd_d                = gp_sh_q[n];
          REG_CTRL:  rd_d                = ctrl_q[n];
          default:   rd_d                = '0;
        endcase
      end
    end
  end

  // State registers; reset has priority over writes and copy/frame pulses.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (res) begin
      // NOTE: the per-layer arrays are real flops whose reset values are
      // visible on the outputs, so they are cleared explicitly.
      for (int n = 0; n < LAYERS; n++) begin
        x_sh_q[n]   <= '0;
        x_act_q[n]  <= '0;
        y_q[n]      <= '0;
        gp_sh_q[n]  <= GPAGE_RST;
        gp_act_q[n] <= GPAGE_RST;
        ctrl_q[n]   <= '0;
      end
      rd_q <= '0;
    end else begin
      x_sh_q   <= x_sh_d;
      x_act_q  <= x_act_d;
      y_q      <= y_d;
      gp_sh_q  <= gp_sh_d;
      gp_act_q <= gp_act_d;
      ctrl_q   <= ctrl_d;
      rd_q     <= rd_d;
    end
  end

  // Flatten active values onto the packed output buses.
  for (genvar g = 0; g < LAYERS; g++) begin : g_pack
    assign x_offs[g*OFFS_W +: OFFS_W] = x_act_q[g];
    assign y_offs[g*OFFS_W +: OFFS_W] = y_q[g];
    assign gpage[g*8 +: 8]            = gp_act_q[g];
  end

  assign rd_data = rd_q;

endmodule

// File: tb/tb_video_layer_ports.sv
// Directed bench for video_layer_ports with three layers (non-power-of-two,
// so layer index 3 is an unpopulated decode), 9-bit offsets, YWRAP = 320.
module tb_video_layer_ports;

  localparam int         LAYERS = 3;
  localparam int         OFFS_W = 9;
  localparam int         YWRAP  = 320;
  localparam logic [7:0] GP_RST = 8'h5A;
  localparam int         AW     = $clog2(LAYERS) + 3;

  logic                     clk = 1'b0;
  logic                     res;
  logic [AW-1:0]            addr;
  logic [7:0]               d;
  logic                     wr;
  logic                     line_start_s;
  logic                     int_start;
  logic [LAYERS*OFFS_W-1:0] x_offs;
  logic [LAYERS*OFFS_W-1:0] y_offs;
  logic [LAYERS*8-1:0]      gpage;
  logic [7:0]               rd_data;

  int checks = 0;
  int errors = 0;

  video_layer_ports #(
    .LAYERS(LAYERS), .OFFS_W(OFFS_W), .YWRAP(YWRAP), .GPAGE_RST(GP_RST)
  ) dut (
    .clk(clk), .res(res), .addr(addr), .d(d), .wr(wr),
    .line_start_s(line_start_s), .int_start(int_start),
    .x_offs(x_offs), .y_offs(y_offs), .gpage(gpage), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input int layer, input int r, input logic [7:0] data);
    addr = AW'(layer * 8 + r);
    d    = data;
    wr   = 1'b1;
    step();
    wr   = 1'b0;
  endtask

  task automatic pulse_line();
    line_start_s = 1'b1; step(); line_start_s = 1'b0;
  endtask

  task automatic pulse_frame();
    int_start = 1'b1; step(); int_start = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    wdata;
    logic [7:0]    exp_rd;
  } vec_t;

  vec_t vecs[30];

  initial begin
    vecs[0]  = '{5'h00, 8'h12, 8'h12};
    vecs[1]  = '{5'h01, 8'hFF, 8'h01};
    vecs[2]  = '{5'h02, 8'h34, 8'h34};
    vecs[3]  = '{5'h03, 8'hFE, 8'h00};
    vecs[4]  = '{5'h04, 8'h77, 8'h77};
    vecs[5]  = '{5'h05, 8'hF2, 8'hF2};
    vecs[6]  = '{5'h06, 8'hAA, 8'h00};
    vecs[7]  = '{5'h07, 8'h55, 8'h00};
    vecs[8]  = '{5'h08, 8'hC3, 8'hC3};
    vecs[9]  = '{5'h09, 8'h03, 8'h01};
    vecs[10] = '{5'h0A, 8'h99, 8'h99};
    vecs[11] = '{5'h0B, 8'h01, 8'h01};
    vecs[12] = '{5'h0C, 8'h3C, 8'h3C};
    vecs[13] = '{5'h0D, 8'h0E, 8'h0E};
    vecs[14] = '{5'h0E, 8'hFF, 8'h00};
    vecs[15] = '{5'h0F, 8'h01, 8'h00};
    vecs[16] = '{5'h10, 8'h81, 8'h81};
    vecs[17] = '{5'h11, 8'h02, 8'h00};
    vecs[18] = '{5'h12, 8'h07, 8'h07};
    vecs[19] = '{5'h13, 8'h81, 8'h01};
    vecs[20] = '{5'h14, 8'hE1, 8'hE1};
    vecs[21] = '{5'h15, 8'h51, 8'h51};
    vecs[22] = '{5'h16, 8'h3F, 8'h00};
    vecs[23] = '{5'h17, 8'hC0, 8'h00};
    vecs[24] = '{5'h18, 8'hFF, 8'h00};
    vecs[25] = '{5'h19, 8'hFF, 8'h00};
    vecs[26] = '{5'h1A, 8'hFF, 8'h00};
    vecs[27] = '{5'h1B, 8'hFF, 8'h00};
    vecs[28] = '{5'h1C, 8'hFF, 8'h00};
    vecs[29] = '{5'h1D, 8'hFF, 8'h00};

    res = 1'b1; addr = '0; d = '0; wr = 1'b0;
    line_start_s = 1'b0; int_start = 1'b0;
    step(); step();

    // T1: reset with a write and both pulses in the same cycle.
    wr = 1'b1; addr = 5'h00; d = 8'hFF; line_start_s = 1'b1; int_start = 1'b1;
    step();
    wr = 1'b0; line_start_s = 1'b0; int_start = 1'b0; res = 1'b0;
    check("t1_x_offs", 64'(x_offs), 64'h0);
    check("t1_y_offs", 64'(y_offs), 64'h0);
    check("t1_gpage",  64'(gpage),  64'h5A5A5A);
    check("t1_rd",     64'(rd_data), 64'h0);
    step();
    check("t1_rd_xl0_after_res_wr", 64'(rd_data), 64'h00);
    addr = 5'h04; step(); step();
    check("t1_rd_gpage0", 64'(rd_data), 64'h5A);

    // T2: line-synchronised X on layer 1.
    wr_reg(1, 0, 8'h34);
    wr_reg(1, 1, 8'h01);
    step();
    check("t2_x1_before_line", 64'(x_offs[17:9]), 64'h000);
    pulse_line();
    check("t2_x1_after_line", 64'(x_offs[17:9]), 64'h134);
    line_start_s = 1'b1;
    wr_reg(1, 0, 8'h55);
    line_start_s = 1'b0;
    check("t2_x1_same_cycle_old", 64'(x_offs[17:9]), 64'h134);
    step();
    check("t2_x1_no_spurious", 64'(x_offs[17:9]), 64'h134);
    pulse_line();
    check("t2_x1_next_line", 64'(x_offs[17:9]), 64'h155);

    // T3: frame-synchronised gpage on layer 0.
    wr_reg(0, 5, 8'h01);
    wr_reg(0, 4, 8'hA0);
    for (int i = 0; i < 3; i++) begin
      pulse_line();
      step();
    end
    check("t3_gp0_after_lines", 64'(gpage[7:0]), 64'h5A);
    pulse_frame();
    check("t3_gp0_after_frame", 64'(gpage[7:0]), 64'hA0);
    check("t3_y_hold_yinc0", 64'(y_offs), 64'h0);

    // T4: Y auto-scroll on layer 2 with yinc = 3.
    wr_reg(2, 5, 8'h30);
    wr_reg(2, 2, 8'h3E);
    wr_reg(2, 3, 8'h01);
    check("t4_y2_written", 64'(y_offs[26:18]), 64'd318);
    pulse_frame();
    check("t4_y2_frame1_wrap", 64'(y_offs[26:18]), 64'd1);
    pulse_frame();
    check("t4_y2_frame2", 64'(y_offs[26:18]), 64'd4);
    pulse_frame();
    check("t4_y2_frame3", 64'(y_offs[26:18]), 64'd7);
    int_start = 1'b1;
    wr_reg(2, 2, 8'h10);
    int_start = 1'b0;
    check("t4_y2_write_wins", 64'(y_offs[26:18]), 64'h010);
    pulse_frame();
    check("t4_y2_after_write", 64'(y_offs[26:18]), 64'h013);
    addr = 5'h12; step(); step();
    check("t4_rd_yl2", 64'(rd_data), 64'h13);
    wr_reg(2, 2, 8'h3D);
    wr_reg(2, 3, 8'h01);
    pulse_frame();
    check("t4_y2_exact_wrap", 64'(y_offs[26:18]), 64'd0);
    check("t4_y01_hold", 64'(y_offs[17:0]), 64'h0);

    // T5: write every register of every decode, read each back.
    foreach (vecs[i]) begin
      addr = vecs[i].a; d = vecs[i].wdata; wr = 1'b1;
      step();
      wr = 1'b0;
      step();
      check($sformatf("t5_rd_addr%02h", vecs[i].a), 64'(rd_data), 64'(vecs[i].exp_rd));
    end
    check("t5_x_offs_no_copy", 64'(x_offs), 64'({9'h000, 9'h155, 9'h000}));
    check("t5_y_offs",         64'(y_offs), 64'({9'h107, 9'h199, 9'h034}));
    check("t5_gpage_no_copy",  64'(gpage),  64'({8'h5A, 8'h5A, 8'hA0}));
    pulse_line();
    check("t5_x_offs_line", 64'(x_offs), 64'({9'h000, 9'h1C3, 9'h112}));
    check("t5_gpage_line",  64'(gpage),  64'({8'h5A, 8'h3C, 8'h77}));

    // T6: reset mid-frame with pending shadow and nonzero yinc.
    wr_reg(1, 0, 8'h11);
    res = 1'b1; step(); res = 1'b0;
    pulse_frame();
    check("t6_x_offs", 64'(x_offs), 64'h0);
    check("t6_y_offs", 64'(y_offs), 64'h0);
    check("t6_gpage",  64'(gpage),  64'h5A5A5A);
    addr = 5'h08; step(); step();
    check("t6_rd_xl1", 64'(rd_data), 64'h00);
    addr = 5'h15; step(); step();
    check("t6_rd_ctrl2", 64'(rd_data), 64'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
